// File: rtl/mem_assem_fifo.sv
// mem_assem_fifo: MEM assembly (guard removal, read id/ordinal tagging, score narrowing) into a show-ahead FIFO; MEM_ASSEM_SCORE_SAT_EN selects score saturation
module mem_assem_fifo #(
  parameter int DEPTH   = 4,
  parameter int POS_W   = 8,
  parameter int KL_W    = 34,
  parameter int S_IN_W  = 32,
  parameter int S_OUT_W = 8,
  parameter int RID_W   = 16,
  parameter int IDX_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RID_W-1:0]   read_id,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  input  logic [POS_W-1:0]   s_i,
  input  logic [POS_W-1:0]   s_j,
  input  logic [KL_W-1:0]    s_k,
  input  logic [KL_W-1:0]    s_l,
  input  logic [S_IN_W-1:0]  s_s,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic [POS_W-1:0]   m_i,
  output logic [POS_W-1:0]   m_j,
  output logic [KL_W-1:0]    m_k,
  output logic [KL_W-1:0]    m_l,
  output logic [S_OUT_W-1:0] m_s,
  output logic [RID_W-1:0]   m_id,
  output logic [IDX_W-1:0]   m_idx,
  output logic               idx_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = 1 + 2*POS_W + 2*KL_W + S_OUT_W + RID_W + IDX_W;
  logic [W-1:0]       r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_first, r_idx_sat, r_idx_ovf;
  logic [RID_W-1:0]   r_id;
  logic [IDX_W-1:0]   r_idx_cnt;
  logic               w_push, w_pop;
  logic [RID_W-1:0]   w_id;
  logic [IDX_W-1:0]   w_idx;
  logic [S_OUT_W-1:0] w_s;
  logic [W-1:0]       w_rec;
  assign s_tready = r_count != (AW+1)'(DEPTH);
  assign m_tvalid = r_count != '0;
  assign idx_ovf  = r_idx_ovf;
  assign w_push   = s_tvalid & s_tready & ~rst;
  assign w_pop    = m_tvalid & m_tready & ~rst;
  assign w_id     = r_first ? read_id : r_id;
  assign w_idx    = r_first ? '0 : r_idx_cnt;
`ifdef MEM_ASSEM_SCORE_SAT_EN
  assign w_s = |s_s[S_IN_W-1:S_OUT_W] ? '1 : s_s[S_OUT_W-1:0];
`else
  assign w_s = s_s[S_OUT_W-1:0];
`endif
  assign w_rec = {s_tlast, s_i - POS_W'(1), s_j, s_k, s_l, w_s, w_id, w_idx};
  assign {m_tlast, m_i, m_j, m_k, m_l, m_s, m_id, m_idx} = r_mem[r_rd_ptr];
  // converted record storage, written on push; contents are don't-care until written
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  // pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // per-read tagging: id latched on the first beat, ordinal saturates, overflow once a beat follows the saturated ordinal
  always_ff @(posedge clk)
    if (rst) begin
      r_first   <= 1'b1;
      r_id      <= '0;
      r_idx_cnt <= '0;
      r_idx_sat <= 1'b0;
      r_idx_ovf <= 1'b0;
    end else if (w_push) begin
      r_first   <= s_tlast;
      r_id      <= w_id;
      r_idx_cnt <= &w_idx ? w_idx : w_idx + IDX_W'(1);
      r_idx_sat <= &w_idx;
      if (!r_first && r_idx_sat) r_idx_ovf <= 1'b1;
    end
endmodule
